// File: rtl/toggle_handshake_receiver_pkg.sv
// Shared definitions for the toggle handshake receiver: FSM state codes and
// default parameter values.
package toggle_handshake_receiver_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/toggle_handshake_receiver_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level (the sender's
// request toggle). Resets to 0.
module toggle_handshake_receiver_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_async,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_handshake_receiver.sv
// Receiving end of a two-phase request/acknowledge link: each synchronised
// req_tgl toggle becomes one valid/ready event; acceptance toggles ack_tgl.
module toggle_handshake_receiver
  import toggle_handshake_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_async,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  input  logic              evt_ready,
  input  logic              clr_err,
  output logic              evt_valid,
  output logic [DATA_W-1:0] evt_data,
  output logic              ack_tgl,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic              proto_err,
  output state_t            dbg_state
);

  localparam int INIT_W = $clog2(SYNC_STAGES + 1);

  // Handshake: evt_valid rises with evt_data stable and stays high until the
  // cycle evt_ready is also high; that edge completes the transfer. evt_ready
  // while evt_valid is low has no effect.

  state_t              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic                req_seen_q, req_seen_d;
  logic [DATA_W-1:0]   evt_data_q, evt_data_d;
  logic                ack_q, ack_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                err_set;
  logic                sync_q;
  logic                toggle_det;

  toggle_handshake_receiver_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .reset_async (reset_async),
    .d           (req_tgl),
    .q           (sync_q)
  );

  assign toggle_det = (sync_q != req_seen_q);

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      req_seen_q <= 1'b0;
      evt_data_q <= '0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      req_seen_q <= req_seen_d;
      evt_data_q <= evt_data_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    req_seen_d = req_seen_q;
    evt_data_d = evt_data_q;
    ack_d      = ack_q;
    cnt_d      = cnt_q;
    err_set    = 1'b0;
    case (state_q)
      // Track the synchronised level until the chain has filled, so the
      // request level present at reset is absorbed rather than seen as an event.
      ST_INIT: begin
        req_seen_d = sync_q;
        if (init_cnt_q == INIT_W'(SYNC_STAGES)) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (toggle_det) begin
          evt_data_d = data_in;
          req_seen_d = sync_q;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (toggle_det) begin
          err_set    = 1'b1;
          req_seen_d = sync_q;
        end
        if (evt_ready) begin
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
    err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  assign evt_valid = (state_q == ST_HOLD);
  assign evt_data  = evt_data_q;
  assign ack_tgl   = ack_q;
  assign evt_cnt   = cnt_q;
  assign proto_err = err_q;
  assign dbg_state = state_q;

endmodule
